ex_muldiv_iter: RTL and testbench
=================================

// Module: ex_muldiv_iter
// PURPOSE
//  Parametrised iterative multiply/divide unit for the EX stage. It replaces the
//  fixed 32-bit mul/div pair with one shared shift/add datapath. It supports signed
//  and unsigned MULT/DIV, valid/ready handshakes on both sides, and an annul (flush)
//  input. Its {hi,lo} result feeds the HI/LO write path towards MEM; EX holds its
//  stall request while busy is high.
// PARAMETERS
//  WIDTH   32  operand width; hi/lo are WIDTH each; one result bit per CALC cycle
//  CNT_W   6   iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//  clk           in   1      clock
//  rst           in   1      synchronous, active-high reset
//  start_valid   in   1      EX presents an operation
//  start_ready   out  1      unit can accept; = (state==IDLE) & ~rst & ~annul
//  op            in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  op_a          in   WIDTH  multiplicand / dividend
//  op_b          in   WIDTH  multiplier / divisor
//  annul         in   1      abort current op (pipeline flush)
//  result_valid  out  1      {hi,lo} holds a valid result
//  result_ready  in   1      consumer takes the result
//  hi            out  WIDTH  product[2W-1:W] / remainder
//  lo            out  WIDTH  product[W-1:0] / quotient
//  busy          out  1      state != IDLE; EX stall request source
// BEHAVIOUR
//  - Reset: state=IDLE, result_valid=0, busy=0, hi=lo=0, counter=0. start_ready=0 while rst is high.
//  - FSM: IDLE -> CALC -> FIX -> DONE -> IDLE.
//  - IDLE: on start_valid & start_ready, latch op, |op_a|, |op_b| (abs only for signed ops)
//    and the sign flags, clear the counter, go to CALC.
//  - CALC: exactly WIDTH edges, one bit per edge. MUL: shift-add on the 2W accumulator.
//    DIV: restoring step on the remainder/quotient registers. Counter reaches WIDTH-1 -> FIX.
//  - FIX: one edge. Sign correction:
//    - MULT: negate the 2W product if sign_a^sign_b.
//    - DIV: negate the quotient if sign_a^sign_b; the remainder takes sign_a.
//    - Then go to DONE.
//  - DONE: result_valid=1. hi/lo stay stable until result_ready is high at an edge,
//    then go to IDLE with result_valid=0.
//  - Latency: result_valid first high after WIDTH+2 edges counted from the accepting edge.
//    That edge moves the unit to CALC, followed by WIDTH CALC edges and 1 FIX edge
//    (34 edges for WIDTH=32).
//  - Throughput: a new start is accepted no earlier than the edge after the result is taken.
//  - Divide by zero (op_b==0, DIV or DIVU): no sign fix; lo=all ones, hi=op_a as presented.
//    Latency is unchanged.
//  - Signed overflow (DIV, op_a=-2^(W-1), op_b=-1): lo=op_a (0x80000000), hi=0, no exception.
//  - annul in any state: next edge -> IDLE, result_valid=0, the result is discarded.
//    annul has priority over result_ready and start_valid (no accept in that cycle).
//  - rst mid-operation: same as annul, and hi/lo are also cleared.
//  - op, op_a and op_b are sampled only on the accepting edge. Later changes are ignored.
//  - Arithmetic is modulo 2W for MUL; abs(-2^(W-1)) is taken as unsigned 2^(W-1).
// TESTING
//  1 MULT 7 x -3 (0xFFFFFFFD) -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; result_valid 34 edges after accept
//  2 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001
//  3 DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0
//  4 DIVU 10/0 -> lo=0xFFFFFFFF, hi=0x0000000A; DIVU 100/7 -> lo=14, hi=2
//  5 Annul 5 edges into CALC -> IDLE on the next edge, result_valid never rises;
//    a following MULTU 3x4 gives lo=12, hi=0
//  6 Hold result_ready low 3 cycles in DONE -> hi/lo/result_valid stable, start_ready=0;
//    WIDTH=8 build: MULTU 0xFF x 0xFF -> hi=0xFE, lo=0x01 after 10 edges

Source files
------------

// File: rtl/ex_muldiv_iter_if.sv
// Handshake and result bus between the EX stage and the iterative mul/div unit.
// The EX side (master) presents operations and consumes results; the unit is the slave.
interface ex_muldiv_iter_if #(
  parameter int WIDTH = 32
);
  logic             start_valid;
  logic             start_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             annul;
  logic             result_valid;
  logic             result_ready;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;

  modport master (
    output start_valid, op, op_a, op_b, annul, result_ready,
    input  start_ready, result_valid, hi, lo, busy
  );

  modport slave (
    input  start_valid, op, op_a, op_b, annul, result_ready,
    output start_ready, result_valid, hi, lo, busy
  );
endinterface

// File: rtl/ex_muldiv_iter.sv
// Iterative multiply/divide unit for the EX stage.
// One shared shift/add datapath produces one result bit per CALC cycle.
// Operands are made non-negative on entry, and the sign is repaired in a single FIX cycle.
// {hi_q, lo_q} serves as the 2W product accumulator for MUL. For DIV it holds the
// remainder in hi_q and the dividend/quotient in lo_q.
module ex_muldiv_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  ex_muldiv_iter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic             accept;
  logic             startReady;

  logic             isDiv_q, isDiv_d;
  logic             signA_q, signA_d;
  logic             signB_q, signB_d;
  logic             divZero_q, divZero_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] rawA_q, rawA_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             opSigned;
  logic [WIDTH-1:0] absA;
  logic [WIDTH-1:0] absB;
  logic [WIDTH:0]   mulSum;
  logic [WIDTH:0]   divShift;
  logic             divGeq;
  logic [WIDTH-1:0] divDiff;
  logic [2*WIDTH-1:0] prodNeg;

  // Magnitudes of the presented operands: abs applies to signed ops only, and -2^(W-1) stays 2^(W-1) unsigned.
  always_comb begin
    opSigned = ~bus.op[0];
    absA     = (opSigned && bus.op_a[WIDTH-1]) ? -bus.op_a : bus.op_a;
    absB     = (opSigned && bus.op_b[WIDTH-1]) ? -bus.op_b : bus.op_b;
  end

  // Single-step arithmetic: a shift-add for MUL, a restoring subtract for DIV, and a 2W negation for the MUL sign fix.
  always_comb begin
    mulSum   = {1'b0, hi_q} + {1'b0, opnd_q};
    divShift = {hi_q, lo_q[WIDTH-1]};
    divGeq   = (divShift >= {1'b0, opnd_q});
    divDiff  = divShift[WIDTH-1:0] - opnd_q;
    prodNeg  = -{hi_q, lo_q};
  end

  // Next-state logic and handshake outputs; annul forces IDLE and blocks any accept in the same cycle.
  always_comb begin
    state_d          = state_q;
    accept           = 1'b0;
    startReady       = (state_q == IDLE) && !rst && !bus.annul;
    bus.start_ready  = startReady;
    bus.result_valid = (state_q == DONE);
    bus.busy         = (state_q != IDLE);
    if (bus.annul) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start_valid && startReady) begin
            accept  = 1'b1;
            state_d = CALC;
          end
        end
        CALC: begin
          if (cnt_q == CntLast) begin
            state_d = FIX;
          end
        end
        FIX: begin
          state_d = DONE;
        end
        DONE: begin
          if (bus.result_ready) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Datapath next values: operands are loaded on accept, iterated in CALC and sign-corrected in FIX.
  always_comb begin
    isDiv_d   = isDiv_q;
    signA_d   = signA_q;
    signB_d   = signB_q;
    divZero_d = divZero_q;
    opnd_d    = opnd_q;
    rawA_d    = rawA_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          isDiv_d   = bus.op[1];
          signA_d   = opSigned & bus.op_a[WIDTH-1];
          signB_d   = opSigned & bus.op_b[WIDTH-1];
          divZero_d = bus.op[1] & (bus.op_b == '0);
          rawA_d    = bus.op_a;
          opnd_d    = bus.op[1] ? absB : absA;
          hi_d      = '0;
          lo_d      = bus.op[1] ? absA : absB;
          cnt_d     = '0;
        end
      end
      CALC: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (isDiv_q) begin
          if (divGeq) begin
            hi_d = divDiff;
            lo_d = {lo_q[WIDTH-2:0], 1'b1};
          end else begin
            hi_d = divShift[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          if (lo_q[0]) begin
            {hi_d, lo_d} = {mulSum, lo_q[WIDTH-1:1]};
          end else begin
            {hi_d, lo_d} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
          end
        end
      end
      FIX: begin
        if (isDiv_q) begin
          if (divZero_q) begin
            lo_d = '1;
            hi_d = rawA_q;
          end else begin
            lo_d = (signA_q ^ signB_q) ? -lo_q : lo_q;
            hi_d = signA_q ? -hi_q : hi_q;
          end
        end else if (signA_q ^ signB_q) begin
          {hi_d, lo_d} = prodNeg;
        end
      end
      default: begin
      end
    endcase
  end

  // FSM state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers; reset clears the result and the counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      isDiv_q   <= 1'b0;
      signA_q   <= 1'b0;
      signB_q   <= 1'b0;
      divZero_q <= 1'b0;
      opnd_q    <= '0;
      rawA_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
    end else begin
      isDiv_q   <= isDiv_d;
      signA_q   <= signA_d;
      signB_q   <= signB_d;
      divZero_q <= divZero_d;
      opnd_q    <= opnd_d;
      rawA_q    <= rawA_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.hi = hi_q;
  assign bus.lo = lo_q;

endmodule

// File: tb/tb_ex_muldiv_iter.sv
// Directed testbench for ex_muldiv_iter: a WIDTH=32 unit plus a WIDTH=8 build.
module tb_ex_muldiv_iter;

  localparam logic [1:0] OpMult  = 2'b00;
  localparam logic [1:0] OpMultu = 2'b01;
  localparam logic [1:0] OpDiv   = 2'b10;
  localparam logic [1:0] OpDivu  = 2'b11;

  logic clk;
  logic rst;
  int   testsRun;
  int   testsFailed;

  ex_muldiv_iter_if #(.WIDTH(32)) bus32 ();
  ex_muldiv_iter_if #(.WIDTH(8))  bus8 ();

  ex_muldiv_iter #(.WIDTH(32), .CNT_W(6)) dut32 (
    .clk(clk),
    .rst(rst),
    .bus(bus32.slave)
  );

  ex_muldiv_iter #(.WIDTH(8), .CNT_W(4)) dut8 (
    .clk(clk),
    .rst(rst),
    .bus(bus8.slave)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Presents one op to the 32-bit unit, scrambles the inputs after the accept,
  // and counts edges from the accepting edge until result_valid (bounded).
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               output int edges);
    @(negedge clk);
    bus32.start_valid = 1'b1;
    bus32.op          = op;
    bus32.op_a        = a;
    bus32.op_b        = b;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    bus32.start_valid = 1'b0;
    bus32.op          = ~op;
    bus32.op_a        = ~a;
    bus32.op_b        = b ^ 32'h5;
    while (!bus32.result_valid && edges < 100) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
  endtask

  task automatic takeResult(input string tag);
    bus32.result_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus32.result_ready = 1'b0;
    checkOutput({tag, "_idle_after_take"}, {62'd0, bus32.result_valid, bus32.busy}, 64'd0);
  endtask

  task automatic runOp(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] expHiLo);
    int edges;
    applyStimulus(op, a, b, edges);
    checkOutput({tag, "_latency"}, 64'(edges), 64'd34);
    checkOutput({tag, "_hilo"}, {bus32.hi, bus32.lo}, expHiLo);
    takeResult(tag);
  endtask

  initial begin
    int edges;
    int rises;
    testsRun    = 0;
    testsFailed = 0;
    rst = 1'b1;
    bus32.start_valid = 1'b0; bus32.op = 2'b00; bus32.op_a = '0; bus32.op_b = '0;
    bus32.annul = 1'b0; bus32.result_ready = 1'b0;
    bus8.start_valid = 1'b0; bus8.op = 2'b00; bus8.op_a = '0; bus8.op_b = '0;
    bus8.annul = 1'b0; bus8.result_ready = 1'b0;

    // Reset state: start_ready is held low while rst is high.
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_hilo", {bus32.hi, bus32.lo}, 64'd0);
    checkOutput("reset_flags", {61'd0, bus32.start_ready, bus32.result_valid, bus32.busy}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_reset", {63'd0, bus32.start_ready}, 64'd1);

    // Signed and unsigned multiply.
    runOp("mult_7_m3", OpMult, 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB);
    runOp("multu_max", OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    runOp("mult_min_min", OpMult, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    runOp("mult_m1_5", OpMult, 32'hFFFF_FFFF, 32'd5, 64'hFFFF_FFFF_FFFF_FFFB);

    // Signed and unsigned divide, including overflow and divide by zero.
    runOp("div_m7_2", OpDiv, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
    runOp("div_7_m2", OpDiv, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD);
    runOp("div_overflow", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
    runOp("divu_10_0", OpDivu, 32'd10, 32'd0, 64'h0000_000A_FFFF_FFFF);
    runOp("div_m5_0", OpDiv, 32'hFFFF_FFFB, 32'd0, 64'hFFFF_FFFB_FFFF_FFFF);
    runOp("divu_100_7", OpDivu, 32'd100, 32'd7, 64'h0000_0002_0000_000E);

    // Annul five edges into CALC: the unit is back in IDLE after the next edge and never signals a result.
    @(negedge clk);
    bus32.start_valid = 1'b1; bus32.op = OpMultu; bus32.op_a = 32'd9; bus32.op_b = 32'd9;
    @(posedge clk);
    @(negedge clk);
    bus32.start_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    bus32.annul = 1'b1;
    checkOutput("annul_blocks_ready", {63'd0, bus32.start_ready}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    bus32.annul = 1'b0;
    checkOutput("annul_to_idle", {62'd0, bus32.busy, bus32.result_valid}, 64'd0);
    rises = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus32.result_valid) rises++;
    end
    checkOutput("annul_no_valid", 64'(rises), 64'd0);
    runOp("multu_3_4", OpMultu, 32'd3, 32'd4, 64'h0000_0000_0000_000C);

    // annul takes priority over start_valid in IDLE.
    @(negedge clk);
    bus32.start_valid = 1'b1; bus32.annul = 1'b1; bus32.op = OpMultu;
    @(posedge clk);
    @(negedge clk);
    bus32.start_valid = 1'b0; bus32.annul = 1'b0;
    checkOutput("annul_beats_start", {63'd0, bus32.busy}, 64'd0);

    // Hold result_ready low in DONE: result stays stable and no new op is accepted.
    applyStimulus(OpDivu, 32'd100, 32'd7, edges);
    checkOutput("hold_latency", 64'(edges), 64'd34);
    bus32.start_valid = 1'b1;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("hold_hilo", {bus32.hi, bus32.lo}, 64'h0000_0002_0000_000E);
      checkOutput("hold_flags", {62'd0, bus32.result_valid, bus32.start_ready}, 64'd2);
    end
    bus32.start_valid = 1'b0;
    takeResult("hold");

    // Synchronous reset mid-operation clears the result and returns to IDLE.
    @(negedge clk);
    bus32.start_valid = 1'b1; bus32.op = OpMultu; bus32.op_a = 32'hFFFF_FFFF; bus32.op_b = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    bus32.start_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    checkOutput("rst_blocks_ready", {63'd0, bus32.start_ready}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_mid_hilo", {bus32.hi, bus32.lo}, 64'd0);
    checkOutput("rst_mid_flags", {62'd0, bus32.busy, bus32.result_valid}, 64'd0);

    // WIDTH=8 build: MULTU 0xFF x 0xFF, result after 10 edges.
    @(negedge clk);
    bus8.start_valid = 1'b1; bus8.op = OpMultu; bus8.op_a = 8'hFF; bus8.op_b = 8'hFF;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    bus8.start_valid = 1'b0; bus8.op_a = 8'h00; bus8.op_b = 8'h00;
    while (!bus8.result_valid && edges < 100) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    checkOutput("w8_latency", 64'(edges), 64'd10);
    checkOutput("w8_hilo", {48'd0, bus8.hi, bus8.lo}, 64'h0000_0000_0000_FE01);
    bus8.result_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus8.result_ready = 1'b0;
    checkOutput("w8_idle_after_take", {62'd0, bus8.result_valid, bus8.busy}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
